// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator blocks.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } calc_state_t;

endpackage

// File: rtl/adder_chunk_cin.sv
// Combinational chunk adder with carry in/out; reused every RUN cycle.
module adder_chunk_cin #(
  parameter int width = 4
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  input  logic             c_i,
  output logic [width-1:0] s_o,
  output logic             c_o
);

  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{width{1'b0}}, c_i};

endmodule

// File: rtl/adder_sub_seq_nbits.sv
// Multi-cycle add/subtract: one chunk per cycle, carry carried between cycles.
module adder_sub_seq_nbits
  import calc_pkg::*;
#(
  parameter int width = 8,
  parameter int chunk = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [width:0]   s_o,
  output logic             ovf_o
);

  localparam int N     = width / chunk;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  calc_state_t      state;
  logic [width-1:0] a_q, b_q;
  logic             sub_q;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [width:0]   s_q;
  logic             ovf_q;

  logic [chunk-1:0] a_sl, b_sl, sum;
  logic             cout;

  // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
  assign a_sl = a_q[idx*chunk +: chunk];
  assign b_sl = b_q[idx*chunk +: chunk] ^ {chunk{sub_q}};

  adder_chunk_cin #(.width(chunk)) u_chunk (
    .a_i (a_sl),
    .b_i (b_sl),
    .c_i (carry),
    .s_o (sum),
    .c_o (cout)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          a_q   <= a_i;
          b_q   <= b_i;
          sub_q <= sub_i;
          carry <= sub_i;
          idx   <= '0;
          ovf_q <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          s_q[idx*chunk +: chunk] <= sum;
          carry <= cout;
          if (idx == LAST) begin
            // Top bit is carry for add, borrow (inverted carry) for sub.
            s_q[width] <= cout ^ sub_q;
            ovf_q <= (a_sl[chunk-1] == b_sl[chunk-1]) && (sum[chunk-1] != a_sl[chunk-1]);
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);
  assign s_o    = s_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_adder_sub_seq_nbits.sv
// Directed and randomized checks of the chunked sequential adder/subtractor.
module tb_adder_sub_seq_nbits;

  localparam int W  = 8;
  localparam int NC = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         sub;
  logic         busy, done, ovf;
  logic [W:0]   s;

  logic         start2;
  logic [15:0]  a2, b2;
  logic         sub2;
  logic         busy2, done2, ovf2;
  logic [16:0]  s2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_sub_seq_nbits #(.width(W), .chunk(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b), .sub_i(sub),
    .busy_o(busy), .done_o(done), .s_o(s), .ovf_o(ovf)
  );

  adder_sub_seq_nbits #(.width(16), .chunk(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .a_i(a2), .b_i(b2), .sub_i(sub2),
    .busy_o(busy2), .done_o(done2), .s_o(s2), .ovf_o(ovf2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start at the next edge, then check latency, pulse width and result.
  task automatic do_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic isub, input logic [W:0] es, input logic eovf);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    for (int i = 1; i <= NC; i++) begin
      @(posedge clk); #1;
      if (i < NC) begin
        chk({tag, ".early_done"}, 32'(done), 32'd0);
        chk({tag, ".run_ovf"}, 32'(ovf), 32'd0);
      end else begin
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".s"}, 32'(s), 32'(es));
        chk({tag, ".ovf"}, 32'(ovf), 32'(eovf));
      end
    end
    @(posedge clk); #1;
    chk({tag, ".done_width"}, 32'(done), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    chk({tag, ".hold_s"}, 32'(s), 32'(es));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rsub;
    logic [W:0]   rs;
    logic         rovf;
    int           dcnt;
    logic [W:0]   scap;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; sub2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.s",    32'(s),    32'd0);
    chk("rst.ovf",  32'(ovf),  32'd0);
    chk("rst.busy16", 32'(busy2), 32'd0);
    chk("rst.s16",    32'(s2),    32'd0);
    rst = 1'b0;

    do_op("add_c8_64", 8'hC8, 8'h64, 1'b0, 9'h12C, 1'b0);
    do_op("sub_5_9",   8'h05, 8'h09, 1'b1, 9'h1FC, 1'b0);
    do_op("sub_80_01", 8'h80, 8'h01, 1'b1, 9'h07F, 1'b1);
    do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 9'h080, 1'b1);
    do_op("add_ff_ff", 8'hFF, 8'hFF, 1'b0, 9'h1FE, 1'b0);
    do_op("sub_0_0",   8'h00, 8'h00, 1'b1, 9'h000, 1'b0);

    // Re-pulsed start and operand change during RUN must be ignored.
    a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'hFF; sub = 1'b1;
    dcnt = 0; scap = '0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (done) begin dcnt++; scap = s; end
      if (i == 2) start = 1'b0;
    end
    chk("ignore.done_count", 32'(dcnt), 32'd1);
    chk("ignore.s", 32'(scap), 32'h030);

    // Reset in the middle of RUN aborts without a done pulse.
    a = 8'h33; b = 8'h44; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.s",    32'(s),    32'd0);
    chk("abort.ovf",  32'(ovf),  32'd0);
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("abort.no_done", 32'(dcnt), 32'd0);
    do_op("post_rst", 8'h01, 8'h01, 1'b0, 9'h002, 1'b0);

    // Single-chunk configuration: one RUN cycle.
    a2 = 16'hFFFF; b2 = 16'h0001; sub2 = 1'b0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("w16.busy", 32'(busy2), 32'd1);
    chk("w16.early_done", 32'(done2), 32'd0);
    @(posedge clk); #1;
    chk("w16.done", 32'(done2), 32'd1);
    chk("w16.s",    32'(s2),    32'h10000);
    chk("w16.ovf",  32'(ovf2),  32'd0);
    @(posedge clk); #1;
    chk("w16.done_width", 32'(done2), 32'd0);

    // Back-to-back random operations against a full-width reference.
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom); rb = W'($urandom); rsub = 1'($urandom);
      if (rsub) rs = {ra < rb, ra - rb};
      else      rs = {1'b0, ra} + {1'b0, rb};
      rovf = (ra[W-1] == (rb[W-1] ^ rsub)) && (rs[W-1] != ra[W-1]);
      do_op("rand", ra, rb, rsub, rs, rovf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_sub_seq_nbits.md
ADDER_SUB_SEQ_NBITS -- requirements
Module: adder_sub_seq_nbits

Interface
REQ-001 The module SHALL have parameter width, default 8, meaning operand width in bits.
REQ-002 The module SHALL have parameter chunk, default 4, meaning bits processed per cycle; width SHALL be an integer multiple of chunk, and N = width/chunk.
REQ-003 The module SHALL have port clk_i, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_i, input, 1 bit, meaning synchronous, active-high reset.
REQ-005 The module SHALL have port start_i, input, 1 bit, meaning request a new operation.
REQ-006 The module SHALL have port a_i, input, width bits, meaning operand A (unsigned or two's complement).
REQ-007 The module SHALL have port b_i, input, width bits, meaning operand B.
REQ-008 The module SHALL have port sub_i, input, 1 bit, meaning 0 = A+B, 1 = A-B.
REQ-009 The module SHALL have port busy_o, output, 1 bit, meaning an operation is in progress (RUN or DONE).
REQ-010 The module SHALL have port done_o, output, 1 bit, meaning one-cycle result-valid pulse.
REQ-011 The module SHALL have port s_o, output, width+1 bits, meaning result; MSB = carry (add) or borrow (sub).
REQ-012 The module SHALL have port ovf_o, output, 1 bit, meaning two's-complement signed overflow of the last operation.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 In IDLE, start_i=1 at an edge SHALL latch a_i, b_i and sub_i, clear the chunk index, set carry = sub_i and move to RUN.
REQ-015 Each RUN edge SHALL compute the chunk slice [idx*chunk +: chunk] as A_slice + (B_slice XOR {chunk{sub}}) + carry, write it into the result register, update carry and increment idx.
REQ-016 After the N-th RUN edge the FSM SHALL enter DONE: start accepted at edge k gives done_o=1 after edge k+N, for exactly one cycle, then IDLE.
REQ-017 For add, s_o SHALL equal {carry_out, sum}, i.e. A+B exact in width+1 bits.
REQ-018 For sub, s_o[width-1:0] SHALL equal (A-B) mod 2^width and s_o[width] SHALL equal NOT carry_out (1 iff A<B unsigned).
REQ-019 ovf_o SHALL be 1 iff the sign bits of A and effective B are equal and differ from the result sign bit.
REQ-020 s_o and ovf_o SHALL hold their values from DONE until the next accepted start; during RUN s_o is undefined-for-use and ovf_o is held at 0.
REQ-021 start_i while busy_o=1 SHALL be ignored with no queuing, and operand or sub_i changes during RUN SHALL have no effect.
REQ-022 Minimum start-to-start spacing SHALL be N+2 cycles (IDLE, N RUN, DONE).
REQ-023 chunk = width (N=1) SHALL be legal, giving a single RUN cycle.

Reset
REQ-024 rst_i=1 at an edge SHALL force IDLE and clear idx, carry and operand registers, and set s_o=0, ovf_o=0, busy_o=0, done_o=0, overriding start_i.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no done_o pulse, and the first start after reset release SHALL behave normally.

Structure
REQ-026 The FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL reside in the shared calculator package calc_pkg for reuse by other sequential calculator blocks.
REQ-027 The chunk arithmetic SHALL be a sub-module adder_chunk_cin (parameter width; ports a_i, b_i, c_i, s_o, c_o), combinational, instantiated once and reused each cycle.
REQ-028 Carry SHALL be the only value passed between cycles; no full-width adder is permitted.

Verification (width=8, chunk=4 unless noted)
REQ-029 Add 0xC8+0x64, start at edge k -> done_o=1 after edge k+2 only, s_o=9'h12C, ovf_o=0.
REQ-030 Sub 5-9 -> s_o=9'h1FC (borrow=1), ovf_o=0; sub 0x80-0x01 -> s_o=9'h07F, ovf_o=1; add 0x7F+0x01 -> s_o=9'h080, ovf_o=1.
REQ-031 Start 0x10+0x20, then re-pulse start_i and change a_i to 0xFF during RUN -> exactly one done_o, s_o=9'h030.
REQ-032 rst_i during RUN -> all outputs 0, no done_o; next start 0x01+0x01 -> s_o=9'h002.
REQ-033 width=16, chunk=16: 0xFFFF+0x0001 -> done after 1 RUN edge, s_o=17'h10000, ovf_o=0.
REQ-034 Run 1000 random add/sub operations, back-to-back at minimum spacing, against a reference model for s_o/ovf_o, with latency and done_o pulse width checked every operation.
